// File: rtl/payload_byte_feeder.sv
// payload_byte_feeder: serialises a keep-masked word stream into one byte per cycle with one-hot decode for the payload engines
// Ports: clk, resetn (async, active-low); s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready word input;
// sod engine clear pulse; en byte strobe; byte_out and dec_char current byte and its one-hot decode;
// eop end-of-packet pulse with pkt_len kept-byte count (saturating).
// Build option CASE_FOLD_EN: fold ASCII 'A'..'Z' to lower case before byte_out/dec_char.
module payload_byte_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  sod,
  output logic                  en,
  output logic [7:0]            byte_out,
  output logic [255:0]          dec_char,
  output logic                  eop,
  output logic [LEN_WIDTH-1:0]  pkt_len
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SOD = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] EOP = 3'd4;
  logic [2:0] r_state, w_nstate;
  logic [DATA_WIDTH-1:0] r_data, w_src_data;
  logic [KEEP_WIDTH-1:0] r_keep, w_src_keep, w_rem;
  logic r_last, w_src_last, w_load, w_src_ext, w_shift, w_en;
  logic [7:0] w_raw, w_byte;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic r_ready, r_sod, r_en, r_eop;
  logic [7:0] r_byte;
  logic [255:0] r_dec;
  logic [LEN_WIDTH-1:0] r_len;
  assign s_tready = r_ready;
  assign sod = r_sod;
  assign en = r_en;
  assign byte_out = r_byte;
  assign dec_char = r_dec;
  assign eop = r_eop;
  assign pkt_len = r_len;
  // w_shift marks an edge into a SHIFT cycle; the byte shown in that cycle comes either from the
  // buffer or, on a mid-packet handshake, straight from the input word so words chain gaplessly.
  always_comb begin
    w_load = r_ready & s_tvalid;
    w_src_ext = w_load & (r_state != IDLE);
    w_src_data = w_src_ext ? s_tdata : r_data;
    w_src_keep = w_src_ext ? s_tkeep : r_keep;
    w_src_last = w_src_ext ? s_tlast : r_last;
    w_rem = w_src_keep & (w_src_keep - KEEP_WIDTH'(1));
    w_shift = (r_state == SOD) | w_src_ext | ((r_state == SHIFT) & (|r_keep));
    w_en = w_shift & (|w_src_keep);
    w_raw = '0;
    for (int i = KEEP_WIDTH - 1; i >= 0; i--)
      if (w_src_keep[i]) w_raw = w_src_data[i*8 +: 8];
`ifdef CASE_FOLD_EN
    w_byte = (w_raw >= 8'h41 && w_raw <= 8'h5A) ? w_raw + 8'h20 : w_raw;
`else
    w_byte = w_raw;
`endif
    w_nstate = (r_state == IDLE) ? (w_load ? SOD : IDLE) :
               (r_state == SOD) ? SHIFT :
               (r_state == EOP) ? IDLE :
               w_shift ? SHIFT :
               (r_state == SHIFT && r_last) ? EOP : WAIT;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_sod <= 1'b0;
      r_en <= 1'b0;
      r_eop <= 1'b0;
      r_byte <= '0;
      r_dec <= '0;
      r_len <= '0;
    end else begin
      r_state <= w_nstate;
      r_sod <= w_nstate == SOD;
      r_eop <= w_nstate == EOP;
      // ready rises in the same cycle the final lane of a non-last word is shown
      r_ready <= (w_nstate == IDLE) | (w_nstate == WAIT) | (w_shift & ~|w_rem & ~w_src_last);
      r_en <= w_en;
      r_byte <= w_en ? w_byte : '0;
      r_dec <= w_en ? (256'(1) << w_byte) : '0;
      if (r_state == IDLE && w_load) begin
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_data <= w_src_data;
        r_keep <= w_rem;
        r_last <= w_src_last;
        if (w_en && ~&r_cnt) r_cnt <= r_cnt + LEN_WIDTH'(1);
      end
      if (w_nstate == EOP) r_len <= r_cnt;
    end
  end
endmodule

// File: tb/tb_payload_byte_feeder.sv
// tb_payload_byte_feeder: directed stimulus with a byte/length scoreboard checked by a separate monitor
module tb_payload_byte_feeder;
  localparam int LW = 4;
  logic clk = 0, resetn = 0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tlast = 0, s_tvalid = 0;
  logic s_tready, sod, en, eop;
  logic [7:0] byte_out;
  logic [255:0] dec_char;
  logic [LW-1:0] pkt_len;
  payload_byte_feeder #(.DATA_WIDTH(64), .LEN_WIDTH(LW)) dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .sod(sod), .en(en), .byte_out(byte_out),
    .dec_char(dec_char), .eop(eop), .pkt_len(pkt_len)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic [LW-1:0] len_q[$];
  int n_en = 0, n_eop = 0, sod_cyc = -1, first_en = -1, last_en = -1, eop_cyc = -1;
  int hs, base;
  localparam logic [63:0] W0 = 64'h0706050403020100;
  localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] W2 = 64'h1716151413121110;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, output int h);
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tvalid = 1;
    h = -1;
    for (int i = 0; i < 100 && h < 0; i++) begin
      if (s_tready) h = cyc;
      tick();
    end
    s_tvalid = 0;
    if (h < 0) chk("handshake_timeout", 1, 0);
  endtask
  task automatic wait_eop(input int target);
    for (int i = 0; i < 200 && n_eop < target; i++) tick();
    chk("eop_seen", n_eop, target);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_sod"}, sod, 0);
    chk({nm, "_en"}, en, 0);
    chk({nm, "_eop"}, eop, 0);
    chk({nm, "_tready"}, s_tready, 0);
    chk({nm, "_byte_out"}, byte_out, 0);
    chk({nm, "_dec_char"}, dec_char, 0);
    chk({nm, "_pkt_len"}, pkt_len, 0);
  endtask
  always @(negedge clk) begin
    logic [7:0] e;
    if (resetn) begin
      chk("sod_en_exclusive", sod & en, 0);
      if (sod) begin
        sod_cyc = cyc;
        first_en = -1;
      end
      if (en) begin
        if (exp_q.size() == 0) chk("unexpected_en", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("byte_out", byte_out, e);
          chk("dec_char", dec_char, 256'(1) << e);
        end
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        n_en++;
      end else chk("dec_char_idle", dec_char, 0);
      if (eop) begin
        if (len_q.size() == 0) chk("unexpected_eop", 1, 0);
        else chk("pkt_len", pkt_len, len_q.pop_front());
        if (first_en >= 0) chk("eop_latency", cyc, last_en + 1);
        eop_cyc = cyc;
        n_eop++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    chk_zero("reset");
    resetn = 1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    len_q.push_back(4'd8);
    send(W0, 8'hFF, 1, hs);
    chk("sod_latency", sod_cyc, hs + 1);
    for (int i = 0; i < 20 && !eop; i++) begin
      chk("tready_busy", s_tready, 0);
      tick();
    end
    chk("tready_at_eop", s_tready, 0);
    chk("first_en_latency", first_en, hs + 2);
    wait_eop(1);
    base = n_en;
    for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
    len_q.push_back(4'd12);
    send(W0, 8'hFF, 0, hs);
    send(W1, 8'h0F, 1, hs);
    wait_eop(2);
    chk("gapless_span", last_en - first_en + 1, 12);
    chk("gapless_count", n_en - base, 12);
    base = n_en;
    for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
    len_q.push_back(4'd12);
    send(W0, 8'hFF, 0, hs);
    for (int i = 0; i < 30 && n_en - base < 8; i++) tick();
    chk("end_of_word_tready", s_tready, 1);
    repeat (3) begin
      tick();
      chk("wait_tready", s_tready, 1);
      chk("wait_en", en, 0);
    end
    send(W1, 8'h0F, 1, hs);
    wait_eop(3);
    chk("delayed_count", n_en - base, 12);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h15);
    exp_q.push_back(8'h17);
    len_q.push_back(4'd4);
    send(W2, 8'hA5, 1, hs);
    wait_eop(4);
    base = n_en;
    len_q.push_back(4'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, hs);
    wait_eop(5);
    chk("empty_no_en", n_en - base, 0);
    chk("empty_sod_cycle", sod_cyc, hs + 1);
    chk("empty_eop_cycle", eop_cyc, hs + 3);
    base = n_en;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    send(W0, 8'hFF, 1, hs);
    for (int i = 0; i < 30 && n_en - base < 3; i++) tick();
    resetn = 0;
    #1;
    chk_zero("midreset");
    repeat (2) tick();
    resetn = 1;
    repeat (12) tick();
    chk("no_eop_after_reset", n_eop, 5);
    chk("reset_queue_drained", exp_q.size(), 0);
`ifdef CASE_FOLD_EN
    exp_q.push_back(8'h74);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h7A);
`else
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h5A);
`endif
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h5B);
    len_q.push_back(4'd5);
    send(64'h0000_005B_405A_6154, 8'h1F, 1, hs);
    wait_eop(6);
    for (int i = 0; i < 24; i++) exp_q.push_back(8'(i));
    len_q.push_back(4'd15);
    send(W0, 8'hFF, 0, hs);
    send(W1, 8'hFF, 0, hs);
    send(W2, 8'hFF, 1, hs);
    wait_eop(7);
    chk("queues_empty", exp_q.size() + len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
